// File: rtl/filter_pkg.sv
// Shared types for the pixel filter chain: frame geometry defaults, RGB565 pixel,
// the beat carried between stages, and the frame reader's scan states.
package filter_pkg;

  localparam int DEF_IMG_WIDTH  = 160;
  localparam int DEF_IMG_HEIGHT = 120;
  localparam int COORD_W        = 10;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               sof;
    logic               eol;
    logic               eof;
    rgb565_t            rgb;
  } pix_beat_t;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } rd_state_e;

endpackage

// File: rtl/pixel_skid_fifo.sv
// Small circular FIFO that absorbs RAM read latency under output backpressure.
// Head entry is presented combinationally; flush empties it in one cycle.
module pixel_skid_fifo
  import filter_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = pix_beat_t,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  T                 wdata,
  input  logic             pop,
  input  logic             flush,
  output T                 rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // NOTE: non-blocking assignments throughout, so every register here updates from
  // the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      // NOTE: storage is reset because the head entry drives module outputs directly,
      // which must read as zero out of reset; at two entries this is cheap.
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/frame_pixel_reader.sv
// Raster-scans a stored RGB565 frame out of a 1-cycle-latency RAM and streams it,
// with coordinates and frame qualifiers, under valid/ready backpressure.
module frame_pixel_reader
  import filter_pkg::*;
#(
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int ADDR_W     = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               mem_rd_en,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [15:0]        mem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COORD_W-1:0] x_local,
  output logic [COORD_W-1:0] y_local,
  output logic [15:0]        rgb565_out,
  output logic               sof,
  output logic               eol,
  output logic               eof
);

  localparam int LAST_ADDR = IMG_WIDTH * IMG_HEIGHT - 1;

  rd_state_e          state;
  rd_state_e          state_next;
  logic               done_next;

  logic [COORD_W-1:0] x_cnt;
  logic [COORD_W-1:0] y_cnt;
  logic [ADDR_W-1:0]  addr_cnt;
  logic               row_end;
  logic               issue;
  logic               last_issue;

  logic               pending;
  logic [COORD_W-1:0] issue_x;
  logic [COORD_W-1:0] issue_y;
  logic               issue_sof;
  logic               issue_eol;
  logic               issue_eof;

  pix_beat_t          push_beat;
  pix_beat_t          head_beat;
  logic [1:0]         fifo_count;
  logic               fifo_full;
  logic               fifo_empty;
  logic [2:0]         in_flight;
  logic               out_fire;

  assign out_valid = !fifo_empty;
  assign out_fire  = out_valid && out_ready;
  assign busy      = (state != IDLE);

  // Reads already in the FIFO or on their way back; a slot freed by this cycle's
  // transfer may be reused immediately, which keeps one pixel per clock.
  assign in_flight  = {1'b0, fifo_count} + {2'b0, pending};
  assign issue      = (state == READ) && !abort && (in_flight < (3'd2 + {2'b0, out_fire}));
  assign row_end    = (x_cnt == COORD_W'(IMG_WIDTH - 1));
  assign last_issue = issue && (addr_cnt == ADDR_W'(LAST_ADDR));

  assign mem_rd_en = issue;
  assign mem_addr  = addr_cnt;

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    state_next = state;
    done_next  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_next = READ;
      end
      READ: begin
        if (last_issue) state_next = DRAIN;
      end
      DRAIN: begin
        // The final beat leaves the FIFO with nothing left in flight.
        if (out_fire && (fifo_count == 2'd1) && !pending) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    if (abort) begin
      state_next = IDLE;
      done_next  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      done  <= done_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_cnt    <= '0;
      y_cnt    <= '0;
      addr_cnt <= '0;
    end else if (abort || state == IDLE) begin
      x_cnt    <= '0;
      y_cnt    <= '0;
      addr_cnt <= '0;
    end else if (issue) begin
      addr_cnt <= addr_cnt + 1'b1;
      if (row_end) begin
        x_cnt <= '0;
        y_cnt <= y_cnt + 1'b1;
      end else begin
        x_cnt <= x_cnt + 1'b1;
      end
    end
  end

  // Coordinates and qualifiers are captured with the read so they pair with its data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending   <= 1'b0;
      issue_x   <= '0;
      issue_y   <= '0;
      issue_sof <= 1'b0;
      issue_eol <= 1'b0;
      issue_eof <= 1'b0;
    end else begin
      pending <= issue;
      if (issue) begin
        issue_x   <= x_cnt;
        issue_y   <= y_cnt;
        issue_sof <= (addr_cnt == '0);
        issue_eol <= row_end;
        issue_eof <= (addr_cnt == ADDR_W'(LAST_ADDR));
      end
    end
  end

  always_comb begin
    push_beat     = '0;
    push_beat.x   = issue_x;
    push_beat.y   = issue_y;
    push_beat.sof = issue_sof;
    push_beat.eol = issue_eol;
    push_beat.eof = issue_eof;
    push_beat.rgb = rgb565_t'(mem_rdata);
  end

  pixel_skid_fifo #(
    .DEPTH (2),
    .T     (pix_beat_t)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (pending),
    .wdata (push_beat),
    .pop   (out_fire),
    .flush (abort),
    .rdata (head_beat),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign x_local    = head_beat.x;
  assign y_local    = head_beat.y;
  assign rgb565_out = head_beat.rgb;
  assign sof        = out_valid && head_beat.sof;
  assign eol        = out_valid && head_beat.eol;
  assign eof        = out_valid && head_beat.eof;

  // Returning data must always find room: the issue rule keeps the FIFO from overflowing.
  no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(pending && fifo_full && !out_fire && !abort));

endmodule

// File: tb/tb_frame_pixel_reader.sv
// Self-checking bench for frame_pixel_reader: a RAM holding RAM[a]=a, a scoreboard
// of the expected raster sequence, and timing/handshake checks.
module tb_frame_pixel_reader;
  import filter_pkg::*;

  localparam int W      = 160;
  localparam int H      = 120;
  localparam int N_PIX  = W * H;
  localparam int ADDR_W = 15;

  logic               clk       = 1'b0;
  logic               reset     = 1'b1;
  logic               start     = 1'b0;
  logic               abort     = 1'b0;
  logic               out_ready = 1'b0;
  logic               busy;
  logic               done;
  logic               mem_rd_en;
  logic [ADDR_W-1:0]  mem_addr;
  logic [15:0]        mem_rdata = '0;
  logic               out_valid;
  logic [COORD_W-1:0] x_local;
  logic [COORD_W-1:0] y_local;
  logic [15:0]        rgb565_out;
  logic               sof;
  logic               eol;
  logic               eof;

  int cyc      = 0;
  int n_checks = 0;
  int n_pass   = 0;

  logic [38:0] exp_q[$];

  bit          rand_ready = 1'b0;
  bit          saw_rd;
  bit          saw_valid;
  bit          stall_prev;
  bit          prev_rd;
  int          first_rd_cyc;
  int          first_valid_cyc;
  int          last_xfer_cyc;
  int          done_cyc;
  logic [ADDR_W-1:0] first_rd_addr;
  logic        done_busy;
  int          n_rd;
  int          n_xfer;
  int          n_done;
  int          n_valid;
  int          max_occ;
  logic [38:0] held_beat;

  frame_pixel_reader #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .ADDR_W     (ADDR_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .x_local    (x_local),
    .y_local    (y_local),
    .rgb565_out (rgb565_out),
    .sof        (sof),
    .eol        (eol),
    .eof        (eof)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Frame-buffer RAM with one cycle of read latency; each word holds its own address.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= {1'b0, mem_addr};
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [38:0] beat_now();
    return {x_local, y_local, sof, eol, eof, rgb565_out};
  endfunction

  task automatic clear_mon();
    saw_rd          = 1'b0;
    saw_valid       = 1'b0;
    stall_prev      = 1'b0;
    prev_rd         = 1'b0;
    first_rd_cyc    = -1;
    first_valid_cyc = -1;
    last_xfer_cyc   = -1;
    done_cyc        = -1;
    first_rd_addr   = '1;
    done_busy       = 1'bx;
    n_rd            = 0;
    n_xfer          = 0;
    n_done          = 0;
    n_valid         = 0;
    max_occ         = 0;
  endtask

  task automatic push_frame();
    for (int i = 0; i < N_PIX; i++) begin
      logic [9:0]  x;
      logic [9:0]  y;
      logic        f_sof;
      logic        f_eol;
      logic        f_eof;
      logic [15:0] rgb;
      x     = 10'(i % W);
      y     = 10'(i / W);
      f_sof = (i == 0);
      f_eol = (i % W == W - 1);
      f_eof = (i == N_PIX - 1);
      rgb   = 16'(i);
      exp_q.push_back({x, y, f_sof, f_eol, f_eof, rgb});
    end
  endtask

  // Observes one cycle at the falling edge.
  task automatic sample();
    int occ;
    occ = n_rd - n_xfer;
    if (occ > max_occ) max_occ = occ;
    if (stall_prev) check("hold", {out_valid, beat_now()}, {1'b1, held_beat});
    if (mem_rd_en) begin
      if (!saw_rd) begin
        saw_rd        = 1'b1;
        first_rd_cyc  = cyc;
        first_rd_addr = mem_addr;
      end
      n_rd++;
    end
    if (out_valid) begin
      n_valid++;
      if (!saw_valid) begin
        saw_valid       = 1'b1;
        first_valid_cyc = cyc;
      end
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) check("extra_beat", 64'd1, 64'd0);
      else check("beat", beat_now(), exp_q.pop_front());
      n_xfer++;
      last_xfer_cyc = cyc;
    end
    if (done) begin
      n_done++;
      done_cyc  = cyc;
      done_busy = busy;
    end
    stall_prev = out_valid && !out_ready;
    held_beat  = beat_now();
    prev_rd    = mem_rd_en;
  endtask

  task automatic tick();
    @(negedge clk);
    if (reset) sample();
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    if (rand_ready) out_ready = ($urandom_range(0, 1) == 1);
  endtask

  task automatic wait_done(input int budget, input bit poke);
    int t;
    t = 0;
    while (n_done == 0 && t < budget) begin
      if (poke && (t % 6000) == 3000) start = 1'b1;
      tick();
      t++;
    end
    check("done_seen", 64'(n_done != 0), 64'd1);
  endtask

  task automatic wait_xfer(input int target, input int budget);
    int t;
    t = 0;
    while (n_xfer < target && t < budget) begin
      tick();
      t++;
    end
    check("xfer_reached", 64'(n_xfer >= target), 64'd1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ctrl"}, {busy, done, mem_rd_en, out_valid, sof, eol, eof}, 64'd0);
    check({tag, "_addr"}, mem_addr, 64'd0);
    check({tag, "_xy"}, {x_local, y_local}, 64'd0);
    check({tag, "_rgb"}, rgb565_out, 64'd0);
  endtask

  initial begin
    int n0;
    int t;

    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    reset     = 1'b1;
    out_ready = 1'b1;
    tick();
    tick();

    // Full frame at full rate, with start-to-output latency and done timing.
    clear_mon();
    exp_q.delete();
    push_frame();
    n0    = cyc;
    start = 1'b1;
    wait_done(N_PIX + 200, 1'b0);
    check("first_rd_cyc", first_rd_cyc, n0 + 1);
    check("first_rd_addr", first_rd_addr, 64'd0);
    check("first_valid_cyc", first_valid_cyc, n0 + 3);
    check("last_xfer_cyc", last_xfer_cyc, n0 + 1 + N_PIX + 2 - 1);
    check("done_cyc", done_cyc, n0 + N_PIX + 3);
    check("done_busy", done_busy, 64'd0);
    repeat (5) tick();
    check("f1_xfers", n_xfer, N_PIX);
    check("f1_done_count", n_done, 64'd1);
    check("f1_queue_left", exp_q.size(), 64'd0);
    check("f1_max_occ", max_occ, 64'd2);
    check("f1_busy_after", busy, 64'd0);

    // Random backpressure, with start pulses ignored while busy.
    clear_mon();
    exp_q.delete();
    push_frame();
    rand_ready = 1'b1;
    start      = 1'b1;
    wait_done(45000, 1'b1);
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    repeat (8) tick();
    check("f3_xfers", n_xfer, N_PIX);
    check("f3_done_count", n_done, 64'd1);
    check("f3_queue_left", exp_q.size(), 64'd0);
    check("f3_max_occ", max_occ, 64'd2);
    check("f3_busy_after", busy, 64'd0);

    // start and abort together while idle: abort wins.
    clear_mon();
    start = 1'b1;
    abort = 1'b1;
    tick();
    check("sa_busy", busy, 64'd0);
    repeat (4) tick();
    check("sa_reads", n_rd, 64'd0);
    check("sa_done", n_done, 64'd0);

    // Downstream stalled from the start: only two reads may be outstanding.
    clear_mon();
    exp_q.delete();
    push_frame();
    out_ready = 1'b0;
    start     = 1'b1;
    t = 0;
    while (!saw_valid && t < 20) begin
      tick();
      t++;
    end
    check("stall_valid_seen", saw_valid, 64'd1);
    repeat (100) tick();
    check("stall_reads", n_rd, 64'd2);
    check("stall_valid", out_valid, 64'd1);
    out_ready = 1'b1;
    wait_xfer(3, 20);
    abort = 1'b1;
    tick();
    stall_prev = 1'b0;
    exp_q.delete();
    check("stall_abort_busy", busy, 64'd0);

    // Abort mid-frame with a read in flight, then rescan from the top.
    clear_mon();
    push_frame();
    out_ready = 1'b1;
    start     = 1'b1;
    wait_xfer(5000, 5100);
    check("abort_pending", prev_rd, 64'd1);
    abort = 1'b1;
    tick();
    stall_prev = 1'b0;
    check("abort_busy", busy, 64'd0);
    check("abort_valid", out_valid, 64'd0);
    n_valid = 0;
    repeat (10) tick();
    check("abort_no_valid", n_valid, 64'd0);
    check("abort_no_done", n_done, 64'd0);
    exp_q.delete();
    clear_mon();
    push_frame();
    start = 1'b1;
    wait_xfer(4, 20);
    check("rescan_addr", first_rd_addr, 64'd0);
    abort = 1'b1;
    tick();
    stall_prev = 1'b0;
    exp_q.delete();

    // Asynchronous reset in the middle of a frame.
    clear_mon();
    push_frame();
    start = 1'b1;
    repeat (50) tick();
    check("pre_reset_busy", busy, 64'd1);
    #2 reset = 1'b0;
    #1;
    check_idle("mid_reset");
    @(posedge clk);
    #1;
    reset      = 1'b1;
    stall_prev = 1'b0;
    exp_q.delete();
    tick();
    check("post_reset_busy", busy, 64'd0);
    check("post_reset_valid", out_valid, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
